ptr_sync_n: RTL and testbench
=============================

# ptr_sync_n

Parametrised multi-channel pointer synchroniser for the asynchronous FIFO family. It generalises the fixed two-flop pointer synchroniser in three ways: configurable depth (STAGES), configurable channel count (CHANNELS), and a post-synchroniser stage. That stage converts each synchronised Gray pointer to binary, pulses on every pointer update, and flags illegal pointer steps with a sticky error. It sits in the destination clock domain, between the source-domain Gray pointer registers and the destination full/empty logic.

## Interface
- ADDR_SIZE, 3, FIFO address bits; pointer width PW = ADDR_SIZE+1 (wrap bit included)
- STAGES, 2, synchroniser flops per channel; legal range 2..4, elaboration error otherwise
- CHANNELS, 1, independent pointers synchronised in parallel; ≥1
- MAX_STEP, 2**ADDR_SIZE, largest legal forward advance (modulo 2**PW) between consecutive synchronised samples

- dclk  in  1  destination clock; only clock in the block
- drst  in  1  reset, synchronous, active-high
- gray_in  in  CHANNELS*PW  source-domain Gray pointers, channel c at [c*PW +: PW]
- err_clr  in  CHANNELS  per-channel clear of step_err
- gray_out  out  CHANNELS*PW  synchronised Gray pointers (last synchroniser flop)
- bin_out  out  CHANNELS*PW  registered binary of gray_out
- ptr_update  out  CHANNELS  one-cycle pulse when bin_out changes
- step_err  out  CHANNELS  sticky illegal-step flag

## Operation
- Per channel: chain s[0..STAGES-1]; s[0] <= gray_in slice, s[i] <= s[i-1]; gray_out = s[STAGES-1].
- Decode stage per channel: bin_nxt = gray2bin(gray_out); bin_out <= bin_nxt every cycle.
- delta = (bin_nxt - bin_out) mod 2**PW, PW bits wide, unsigned.
- ptr_update <= (delta != 0).
- Step error: set when delta > MAX_STEP. A backward step appears as a large delta and therefore sets the error.
- step_err clears on err_clr[c]. If set and clear occur in the same cycle, set wins.
- Wrap-around is handled purely by modulo subtraction. Example with PW=4: bin_out 15 -> 0 gives delta 1, which is legal.
- Channels are fully independent; there is no cross-channel logic.
- Reset: all s[], gray_out, bin_out, ptr_update and step_err go to 0 on any dclk edge with drst=1. The reset state corresponds to pointer 0, so the first post-reset compare is against 0.
- Reset mid-operation: all state returns to 0 in the same edge, and no ptr_update pulse is generated by reset itself. After drst deasserts, a nonzero gray_in produces a normal update, which is checked against pointer 0.

## Timing
- gray_out reflects the gray_in value sampled STAGES dclk edges earlier.
- bin_out, ptr_update and step_err lag gray_out by exactly 1 edge, i.e. STAGES+1 edges from the gray_in sample.
- ptr_update is high for exactly one cycle per change of bin_out. Back-to-back changes produce back-to-back pulses.
- err_clr takes effect on the next edge. step_err stays asserted until it is cleared or reset.
- No combinational path from any input to any output.

## Structure
- Package ptr_sync_pkg:
  - function gray2bin(PW-bit)
  - function bin2gray(PW-bit), used by the bench and by source-side blocks
  - localparam STAGES_MIN = 2 and STAGES_MAX = 4
- Sub-module sync_chain: a WIDTH-bit, STAGES-deep flop chain on dclk/drst with reset-to-0. Instantiate one per channel via a generate loop.
- The decode, compare and error logic lives in ptr_sync_n as a per-channel generate block.

## Test plan
- Reset/latency. Setup: ADDR_SIZE=3, STAGES=2. Hold drst 3 cycles, then drive gray_in=bin2gray(1)=0001. Required: all outputs 0 during reset; gray_out=0001 after 2 edges; bin_out=1 and ptr_update=1 after 3 edges; ptr_update=0 on the next cycle.
- Wrap-around. Drive Gray for 14, 15, 0, 1 on consecutive cycles. Required: bin_out 14, 15, 0, 1 with ptr_update high each cycle, and step_err stays 0.
- Step error plus clear. Setup: MAX_STEP=8. Jump from 2 to 12 (delta 10). Required: step_err=1 at the bin_out=12 cycle. Assert err_clr together with a new illegal step. Required: step_err remains 1, then clears on the next err_clr-only cycle.
- Backward step. Drive 5 then 4. Required: delta=15 > MAX_STEP, so step_err=1 and ptr_update=1.
- Multi-channel and STAGES=3. Setup: CHANNELS=3. Channel 1 counts, channels 0 and 2 hold. Required: only ptr_update[1] toggles, with latency 4 edges.
- Reset mid-run. Assert drst while step_err=1 and bin_out=9. Required: all outputs 0 after that edge, with no ptr_update pulse.

Source files
------------

// File: rtl/ptr_sync_pkg.sv
// Shared helpers for the async FIFO pointer synchronisers: Gray/binary
// conversion on a fixed maximum width and the legal synchroniser depth range.
package ptr_sync_pkg;

    localparam int PTR_MAX_W  = 32;
    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;

    // Narrower pointers are zero-extended; leading zeros decode to zeros.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/ptr_sync_n_sync_chain.sv
// WIDTH-bit, STAGES-deep synchroniser flop chain, synchronous reset to zero.
module sync_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             dclk,
    input  logic             drst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the sampled value one flop deeper on every destination edge.
    always_ff @(posedge dclk) begin
        if (drst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/ptr_sync_n.sv
// Multi-channel Gray pointer synchroniser with binary decode, update pulse
// and sticky illegal-step detection, all in the destination clock domain.
module ptr_sync_n
    import ptr_sync_pkg::*;
#(
    parameter int ADDR_SIZE = 3,
    parameter int STAGES    = 2,
    parameter int CHANNELS  = 1,
    parameter int MAX_STEP  = 2 ** ADDR_SIZE
) (
    input  logic                                dclk,
    input  logic                                drst,
    input  logic [CHANNELS*(ADDR_SIZE+1)-1:0]   gray_in,
    input  logic [CHANNELS-1:0]                 err_clr,
    output logic [CHANNELS*(ADDR_SIZE+1)-1:0]   gray_out,
    output logic [CHANNELS*(ADDR_SIZE+1)-1:0]   bin_out,
    output logic [CHANNELS-1:0]                 ptr_update,
    output logic [CHANNELS-1:0]                 step_err
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PTR_MAX_W-1:0] MAX_STEP_L = PTR_MAX_W'(MAX_STEP);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("ptr_sync_n: STAGES must lie in 2..4");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("ptr_sync_n: CHANNELS must be at least 1");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PW-1:0]        gray_s;
        logic [PTR_MAX_W-1:0] gray_wide_s;
        logic [PTR_MAX_W-1:0] bin_wide_s;
        logic [PW-1:0]        bin_nxt_s;
        logic [PW-1:0]        delta_s;
        logic                 illegal_s;
        logic [PW-1:0]        bin_r;
        logic                 upd_r;
        logic                 err_r;

        sync_chain #(
            .WIDTH  (PW),
            .STAGES (STAGES)
        ) u_chain (
            .dclk (dclk),
            .drst (drst),
            .d    (gray_in[c*PW +: PW]),
            .q    (gray_s)
        );

        // Decode and measure the forward distance; modulo subtraction covers wrap.
        always_comb begin
            gray_wide_s          = '0;
            gray_wide_s[PW-1:0]  = gray_s;
            bin_wide_s           = gray2bin(gray_wide_s);
            bin_nxt_s            = bin_wide_s[PW-1:0];
            delta_s              = bin_nxt_s - bin_r;
            illegal_s            = (PTR_MAX_W'(delta_s) > MAX_STEP_L);
        end

        // Registered decode stage; a new illegal step outranks a clear.
        always_ff @(posedge dclk) begin
            if (drst) begin
                bin_r <= '0;
                upd_r <= 1'b0;
                err_r <= 1'b0;
            end else begin
                bin_r <= bin_nxt_s;
                upd_r <= (delta_s != '0);
                if (illegal_s) begin
                    err_r <= 1'b1;
                end else if (err_clr[c]) begin
                    err_r <= 1'b0;
                end else begin
                    err_r <= err_r;
                end
            end
        end

        assign gray_out[c*PW +: PW] = gray_s;
        assign bin_out[c*PW +: PW]  = bin_r;
        assign ptr_update[c]        = upd_r;
        assign step_err[c]          = err_r;
    end

endmodule

// File: tb/tb_ptr_sync_n.sv
// Randomised scoreboard bench for ptr_sync_n: a per-edge pointer history model
// predicts every output, a separate monitor compares after each edge.
module tb_ptr_sync_n;
    import ptr_sync_pkg::*;

    localparam int AS   = 3;
    localparam int PW   = AS + 1;
    localparam int ST   = 3;
    localparam int CH   = 3;
    localparam int MX   = 8;
    localparam int MOD  = 2 ** PW;
    localparam int MAXE = 4096;

    logic               dclk = 1'b0;
    logic               drst = 1'b1;
    logic [CH*PW-1:0]   gray_in = '0;
    logic [CH-1:0]      err_clr = '0;
    logic [CH*PW-1:0]   gray_out;
    logic [CH*PW-1:0]   bin_out;
    logic [CH-1:0]      ptr_update;
    logic [CH-1:0]      step_err;

    ptr_sync_n #(
        .ADDR_SIZE (AS),
        .STAGES    (ST),
        .CHANNELS  (CH),
        .MAX_STEP  (MX)
    ) dut (
        .dclk       (dclk),
        .drst       (drst),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .gray_out   (gray_out),
        .bin_out    (bin_out),
        .ptr_update (ptr_update),
        .step_err   (step_err)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        int               e;
        logic [CH*PW-1:0] g;
        logic [CH*PW-1:0] b;
        logic [CH-1:0]    u;
        logic [CH-1:0]    er;
    } exp_t;

    exp_t sb_q[$];

    int unsigned p_a   [0:CH-1][0:MAXE-1];
    bit          clr_a [0:CH-1][0:MAXE-1];
    bit          rst_a [0:MAXE-1];
    int unsigned prev_bin [CH];
    bit          prev_err [CH];
    int unsigned cur_p [CH];
    int          e_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    bit          stim_done = 1'b0;

    // True if any edge in [lo,hi] reset the block (edges before the first count as reset).
    function automatic bit rst_in(int lo, int hi);
        for (int k = lo; k <= hi; k++) begin
            if (k < 1 || rst_a[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int unsigned to_gray(int unsigned p);
        return p ^ (p >> 1);
    endfunction

    // Drive one edge's inputs, log them, and push the expected post-edge state.
    task automatic drive(input int unsigned q0, input int unsigned q1, input int unsigned q2,
                         input bit r, input bit [CH-1:0] c);
        exp_t x;
        logic [PTR_MAX_W-1:0] gw;
        int unsigned b, d;
        bit u, er;
        @(negedge dclk);
        cur_p[0] = q0 % MOD;
        cur_p[1] = q1 % MOD;
        cur_p[2] = q2 % MOD;
        e_cnt++;
        rst_a[e_cnt] = r;
        for (int ch = 0; ch < CH; ch++) begin
            p_a[ch][e_cnt]   = cur_p[ch];
            clr_a[ch][e_cnt] = c[ch];
            gw = bin2gray(PTR_MAX_W'(cur_p[ch]));
            gray_in[ch*PW +: PW] = gw[PW-1:0];
        end
        drst    = r;
        err_clr = c;

        x.e = e_cnt;
        x.g = '0; x.b = '0; x.u = '0; x.er = '0;
        for (int ch = 0; ch < CH; ch++) begin
            if (!rst_in(e_cnt - ST + 1, e_cnt))
                x.g[ch*PW +: PW] = PW'(to_gray(p_a[ch][e_cnt-ST+1]));
            b = rst_in(e_cnt - ST, e_cnt) ? 0 : p_a[ch][e_cnt-ST];
            if (rst_a[e_cnt]) begin
                u  = 1'b0;
                er = 1'b0;
            end else begin
                d  = (b + MOD - prev_bin[ch]) % MOD;
                u  = (d != 0);
                er = (d > MX) ? 1'b1 : (clr_a[ch][e_cnt] ? 1'b0 : prev_err[ch]);
            end
            x.b[ch*PW +: PW] = PW'(b);
            x.u[ch]  = u;
            x.er[ch] = er;
            prev_bin[ch] = b;
            prev_err[ch] = er;
        end
        sb_q.push_back(x);
    endtask

    task automatic hold1(input int unsigned p1, input int n);
        for (int i = 0; i < n; i++) drive(cur_p[0], p1, cur_p[2], 1'b0, 3'b000);
    endtask

    // Monitor: after each edge, pop the prediction for that edge and compare.
    initial begin : monitor
        exp_t x;
        int   mon_e;
        mon_e = 0;
        @(posedge dclk);
        forever begin
            @(posedge dclk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                mon_e++;
                checks += 5;
                if (x.e != mon_e) begin
                    failures++;
                    $display("FAIL edge_order: got edge %0d expected %0d", x.e, mon_e);
                end
                if (gray_out !== x.g) begin
                    failures++;
                    $display("FAIL gray_out edge %0d: got %h expected %h", x.e, gray_out, x.g);
                end
                if (bin_out !== x.b) begin
                    failures++;
                    $display("FAIL bin_out edge %0d: got %h expected %h", x.e, bin_out, x.b);
                end
                if (ptr_update !== x.u) begin
                    failures++;
                    $display("FAIL ptr_update edge %0d: got %b expected %b", x.e, ptr_update, x.u);
                end
                if (step_err !== x.er) begin
                    failures++;
                    $display("FAIL step_err edge %0d: got %b expected %b", x.e, step_err, x.er);
                end
            end
        end
    end

    initial begin : stimulus
        int unsigned r, np;
        bit [CH-1:0] c;
        bit rs;
        for (int ch = 0; ch < CH; ch++) begin
            prev_bin[ch] = 0;
            prev_err[ch] = 1'b0;
            cur_p[ch]    = 0;
        end

        // Reset, then first update on channel 1 and a one-off move on channel 2.
        repeat (3) drive(0, 0, 0, 1'b1, 3'b000);
        drive(0, 1, 3, 1'b0, 3'b000);
        hold1(1, 5);
        // Count up through the wrap: 13,14,15,0,1 back to back.
        foreach (cur_p[i]) ;
        drive(0, 5, 3, 1'b0, 3'b000);
        drive(0, 9, 3, 1'b0, 3'b000);
        drive(0, 13, 3, 1'b0, 3'b000);
        drive(0, 14, 3, 1'b0, 3'b000);
        drive(0, 15, 3, 1'b0, 3'b000);
        drive(0, 0, 3, 1'b0, 3'b000);
        drive(0, 1, 3, 1'b0, 3'b000);
        hold1(1, 4);
        // Illegal jump 2 -> 12, then clear coinciding with a second illegal step.
        hold1(2, 5);
        hold1(12, 5);
        hold1(6, ST);
        drive(0, 6, 3, 1'b0, 3'b010);
        hold1(6, 2);
        drive(0, 6, 3, 1'b0, 3'b010);
        hold1(6, 3);
        // Backward step 5 -> 4.
        hold1(5, 4);
        hold1(4, 5);
        // Mid-run reset with step_err set and bin_out at 9.
        hold1(9, ST + 2);
        drive(0, 9, 3, 1'b1, 3'b000);
        hold1(9, ST + 3);

        // Randomised traffic on all channels with occasional clears and resets.
        for (int n = 0; n < 900; n++) begin
            for (int ch = 0; ch < CH; ch++) begin
                r = $urandom_range(0, 99);
                if (r < 45)      np = cur_p[ch] + $urandom_range(0, MX);
                else if (r < 75) np = cur_p[ch];
                else if (r < 88) np = cur_p[ch] + 1;
                else             np = cur_p[ch] + $urandom_range(MX + 1, MOD - 1);
                cur_p[ch] = np % MOD;
                c[ch] = ($urandom_range(0, 9) == 0);
            end
            rs = ($urandom_range(0, 99) == 0);
            drive(cur_p[0], cur_p[1], cur_p[2], rs, c);
        end

        repeat (3) @(negedge dclk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
